// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one inverse round per clock over an externally held key schedule.
// Plaintext is presented on a valid/ready port and held until the next block finishes.
module aes_decrypt_iter #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          ciphertext,
  input  logic [0:(nr+1)*128-1] w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          plaintext,
  output logic                  busy
);
  localparam int RW = $clog2(nr + 1);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  if (nr != nk + 6) begin : g_cfg_check
    $error("aes_decrypt_iter: nr must equal nk+6");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  state_e          st_q, st_d;
  logic [RW-1:0]   rnd_q, rnd_d;
  logic [127:0]    state_q, state_d, pt_q, pt_d;
  logic [127:0]    shifted, subbed, rk_sel, added, mixed;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[(255 - int'(x))*8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // k selects which of b, 2b, 4b, 8b are summed; constants 0e/0b/0d/09 reduce to xtime chains
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (k[3] ? b8 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction

  // Shared round datapath: ROUND consumes mixed, FINAL consumes added with rk[0]
  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    rk_sel  = w[0 +: 128];
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        shifted[127 - 8*(r + 4*c) -: 8] = state_q[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
    for (int unsigned i = 0; i < 16; i++)
      subbed[127 - 8*i -: 8] = inv_sbox(shifted[127 - 8*i -: 8]);
    if (st_q != FINAL)
      for (int unsigned r = 1; r <= nr; r++)
        if (rnd_q == RW'(r)) rk_sel = w[r*128 +: 128];
    added = subbed ^ rk_sel;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        mixed[127 - 8*(r + 4*c) -: 8] =
            gmul(added[127 - 8*(4*c + r) -: 8], 4'he)
          ^ gmul(added[127 - 8*(4*c + (r + 1) % 4) -: 8], 4'hb)
          ^ gmul(added[127 - 8*(4*c + (r + 2) % 4) -: 8], 4'hd)
          ^ gmul(added[127 - 8*(4*c + (r + 3) % 4) -: 8], 4'h9);
  end

  always_comb begin
    st_d    = st_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    pt_d    = pt_q;
    case (st_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ciphertext ^ w[nr*128 +: 128];
          rnd_d   = RW'(nr - 1);
          st_d    = ROUND;
        end
      end
      ROUND: begin
        state_d = mixed;
        rnd_d   = rnd_q - RW'(1);
        if (rnd_q == RW'(1)) st_d = FINAL;
      end
      FINAL: begin
        pt_d = added;
        st_d = DONE;
      end
      DONE: begin
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      pt_q    <= '0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      pt_q    <= pt_d;
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign busy      = (st_q != IDLE);
  assign out_valid = (st_q == DONE);
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: a FIPS-197 model (tables derived from GF(2^8) arithmetic) drives
// a cycle-level expectation for the AES-128 instance; AES-192/256 instances are checked directly.
module tb_aes_decrypt_iter;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ct, plaintext;
  logic [0:1407] w10;
  logic iv6, ir6, ov6, busy6;
  logic [127:0] pt6;
  logic [0:1663] w12;
  logic iv8, ir8, ov8, busy8;
  logic [127:0] pt8;
  logic [0:1919] w14;

  always #5 clk = ~clk;

  aes_decrypt_iter #(.nk(4), .nr(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ciphertext(ct), .w(w10),
    .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext), .busy(busy));
  aes_decrypt_iter #(.nk(6), .nr(12)) dut192 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .ciphertext(ct), .w(w12),
    .out_valid(ov6), .out_ready(out_ready), .plaintext(pt6), .busy(busy6));
  aes_decrypt_iter #(.nk(8), .nr(14)) dut256 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .ciphertext(ct), .w(w14),
    .out_valid(ov8), .out_ready(out_ready), .plaintext(pt8), .busy(busy8));

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [0:1919] key_expand(input logic [255:0] key, input int nk);
    logic [31:0] wd [60];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [0:1919] ks;
    int nw;
    ks = '0;
    rc = 8'h01;
    nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) wd[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = wd[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      wd[i] = wd[i-nk] ^ tmp;
    end
    for (int i = 0; i < nw; i++) ks[i*32 +: 32] = wd[i];
    return ks;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] blk, input logic [0:1919] ks, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = blk[127 - 8*i -: 8] ^ ks[8*i +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q + 4*c] = t[q + 4*((c + q) % 4)];
      if (r != nr)
        for (int c = 0; c < 4; c++) begin
          for (int q = 0; q < 4; q++) t[q] = s[4*c + q];
          for (int q = 0; q < 4; q++)
            s[4*c + q] = gm(t[q], 8'h02) ^ gm(t[(q+1)%4], 8'h03) ^ t[(q+2)%4] ^ t[(q+3)%4];
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[r*128 + 8*i +: 8];
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] blk, input logic [0:1919] ks, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = blk[127 - 8*i -: 8] ^ ks[nr*128 + 8*i +: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[q + 4*c] = s[q + 4*((c + 4 - q) % 4)];
      for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ ks[r*128 + 8*i +: 8];
      if (r != 0)
        for (int c = 0; c < 4; c++) begin
          for (int q = 0; q < 4; q++) t[q] = s[4*c + q];
          for (int q = 0; q < 4; q++)
            s[4*c + q] = gm(t[q], 8'h0e) ^ gm(t[(q+1)%4], 8'h0b) ^ gm(t[(q+2)%4], 8'h0d) ^ gm(t[(q+3)%4], 8'h09);
        end
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // Expectation for the AES-128 instance: idle / computing (cycles left) / holding result
  int m_phase, m_left;
  logic [127:0] m_exp, m_pt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_exp   <= '0;
      m_pt    <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_exp   <= aes_dec(ct, {w10, 512'h0}, 10);
             m_left  <= 10;
             m_phase <= 1;
           end
        1: begin
             m_left <= m_left - 1;
             if (m_left == 1) begin
               m_phase <= 2;
               m_pt    <= m_exp;
             end
           end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  int cyc = 0;
  int dut_acc [$];
  logic [127:0] outq [$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) dut_acc.push_back(cyc);
    if (out_valid && out_ready) outq.push_back(plaintext);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int which, output int n);
    n = 0;
    while (n < 60 && !((which == 0) ? out_valid : (which == 1) ? ov6 : ov8)) begin
      tick();
      n++;
    end
  endtask

  logic [0:1919] ks10, ks12, ks14, ksr;
  logic [127:0] pt2, ct2, ptr, ctr;
  logic [7:0] inv_b, aff;
  int n, a0, o0, diff;

  initial begin
    for (int x = 0; x < 256; x++) begin
      inv_b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv_b = 8'(y);
      aff = inv_b ^ rotl1(inv_b) ^ rotl1(rotl1(inv_b)) ^ rotl1(rotl1(rotl1(inv_b)))
          ^ rotl1(rotl1(rotl1(rotl1(inv_b)))) ^ 8'h63;
      sb[x] = aff;
      isb[aff] = 8'(x);
    end
    ks10 = key_expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    ks12 = key_expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    ks14 = key_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    chk("model_sbox53", {120'h0, sb[8'h53]}, 128'hed);
    chk("model_rk10", ks10[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_enc128", aes_enc(PT, ks10, 10), CT128);
    chk("model_dec128", aes_dec(CT128, ks10, 10), PT);
    chk("model_dec192", aes_dec(CT192, ks12, 12), PT);
    chk("model_dec256", aes_dec(CT256, ks14, 14), PT);

    w10 = ks10[0:1407];
    w12 = ks12[0:1663];
    w14 = ks14;
    in_valid = 0; iv6 = 0; iv8 = 0; out_ready = 0; ct = '0;
    rst = 1;
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          checks++;
          if (in_ready !== (m_phase == 0) || busy !== (m_phase != 0) ||
              out_valid !== (m_phase == 2) || plaintext !== m_pt) begin
            errors++;
            $display("FAIL cycle_model t=%0t ir=%b busy=%b ov=%b pt=%h want ir=%b busy=%b ov=%b pt=%h",
                     $time, in_ready, busy, out_valid, plaintext,
                     m_phase == 0, m_phase != 0, m_phase == 2, m_pt);
          end
        end
      end
    join_none

    repeat (3) tick();
    chk("reset_busy", {127'h0, busy}, 128'h0);
    chk("reset_out_valid", {127'h0, out_valid}, 128'h0);
    chk("reset_plaintext", plaintext, 128'h0);
    rst = 0;
    tick();
    chk("idle_in_ready", {127'h0, in_ready}, 128'h1);

    // AES-128 with backpressure; a second offer while holding must be ignored
    ct = CT128; in_valid = 1;
    tick();
    in_valid = 0; ct = {$urandom, $urandom, $urandom, $urandom};
    wait_valid(0, n);
    chk("latency128", 128'(n), 128'd10);
    chk("plaintext128", plaintext, PT);
    in_valid = 1;
    repeat (5) begin
      tick();
      chk("bp_out_valid", {127'h0, out_valid}, 128'h1);
      chk("bp_in_ready", {127'h0, in_ready}, 128'h0);
    end
    in_valid = 0; out_ready = 1;
    tick();
    chk("after_hs_in_ready", {127'h0, in_ready}, 128'h1);

    // Back-to-back with out_ready held high
    pt2 = 128'hdeadbeef0123456789abcdeffedcba98;
    ct2 = aes_enc(pt2, ks10, 10);
    a0 = dut_acc.size();
    o0 = outq.size();
    ct = CT128; in_valid = 1;
    tick();
    ct = ct2;
    n = 0;
    while (n < 40 && !in_ready) begin
      tick();
      n++;
    end
    tick();
    in_valid = 0;
    wait_valid(0, n);
    tick();
    diff = (dut_acc.size() >= a0 + 2) ? dut_acc[a0+1] - dut_acc[a0] : -1;
    chk("b2b_accept_gap", 128'(diff), 128'd12);
    chk("b2b_first", (outq.size() > o0) ? outq[o0] : 128'hx, PT);
    chk("b2b_second", (outq.size() > o0 + 1) ? outq[o0+1] : 128'hx, pt2);

    // Asynchronous reset four cycles into a block
    ct = CT128; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (4) tick();
    rst = 1;
    #1;
    chk("midrst_busy", {127'h0, busy}, 128'h0);
    chk("midrst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("midrst_plaintext", plaintext, 128'h0);
    tick();
    rst = 0;

    // Round trip through the bench encryptor with fresh keys
    for (int k = 0; k < 100; k++) begin
      ksr = key_expand({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4);
      w10 = ksr[0:1407];
      ptr = {$urandom, $urandom, $urandom, $urandom};
      ctr = aes_enc(ptr, ksr, 10);
      ct = ctr; in_valid = 1;
      tick();
      in_valid = 0;
      wait_valid(0, n);
      chk("roundtrip", plaintext, ptr);
      tick();
    end

    ct = CT192; iv6 = 1;
    tick();
    iv6 = 0;
    wait_valid(1, n);
    chk("latency192", 128'(n), 128'd12);
    chk("plaintext192", pt6, PT);
    tick();
    chk("idle192", {126'h0, ir6, busy6}, 128'h2);

    ct = CT256; iv8 = 1;
    tick();
    iv8 = 0;
    wait_valid(2, n);
    chk("latency256", 128'(n), 128'd14);
    chk("plaintext256", pt8, PT);
    tick();
    chk("idle256", {126'h0, ir8, busy8}, 128'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
